// File: rtl/imem_loader.sv
// Program loader: packs a valid/ready byte stream big-endian into 32-bit words
// and writes them to consecutive IMEM addresses while holding the CPU.
module imem_loader #(
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic              SYS_clk,
   input  logic              SYS_reset,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [CNT_W-1:0]  load_words,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic [7:0]        checksum
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

   state_t            state, state_next;
   logic [TMR_W-1:0]  timer;
   logic [1:0]        byte_idx;
   logic [31:0]       word;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  remaining;
   logic [7:0]        sum;
   logic              zero_done;
   logic              accept;
   logic              start_ok;

   assign accept   = (state == RECV) && byte_valid;
   assign start_ok = load_start && ((state == IDLE) || (state == ERR));

   always_comb begin
      state_next = state;
      case (state)
         IDLE, ERR: begin
            if (load_start)
               state_next = (load_words != '0) ? RECV : IDLE;
         end
         RECV: begin
            if (accept && (byte_idx == 2'd3))
               state_next = WRITE;
            else if (!accept && (timer == TMR_W'(TIMEOUT - 1)))
               state_next = ERR;
         end
         WRITE:   state_next = (remaining == CNT_W'(1)) ? DONE : RECV;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         state     <= IDLE;
         timer     <= '0;
         byte_idx  <= '0;
         word      <= '0;
         addr      <= '0;
         remaining <= '0;
         sum       <= '0;
         zero_done <= 1'b0;
      end else begin
         state     <= state_next;
         zero_done <= start_ok && (load_words == '0);

         if (start_ok) begin
            addr      <= load_base & ~ADDR_W'(3);
            remaining <= load_words;
            sum       <= '0;
         end

         // A fresh load always starts at byte 0; a discarded partial word is simply overwritten.
         if (accept) begin
            word     <= {word[23:0], byte_data};
            sum      <= sum + byte_data;
            byte_idx <= byte_idx + 2'd1;
         end else if (state != RECV) begin
            byte_idx <= '0;
         end

         if ((state == RECV) && !accept)
            timer <= timer + TMR_W'(1);
         else
            timer <= '0;

         if (state == WRITE) begin
            addr      <= addr + ADDR_W'(4);
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

   assign byte_ready = (state == RECV);
   assign imem_we    = (state == WRITE);
   assign imem_addr  = addr;
   assign imem_wdata = word;
   assign cpu_hold   = (state == RECV) || (state == WRITE) || (state == DONE) || (state == ERR);
   assign load_busy  = (state == RECV) || (state == WRITE) || (state == DONE);
   assign load_done  = (state == DONE) || zero_done;
   assign load_err   = (state == ERR);
   assign checksum   = sum;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IMEM writes are queued by the
// stimulus and checked by an independent write monitor.
module tb_imem_loader;

   logic        SYS_clk;
   logic        SYS_reset;
   logic        load_start;
   logic [31:0] load_base;
   logic [15:0] load_words;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        load_busy;
   logic        load_done;
   logic        load_err;
   logic [7:0]  checksum;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  total_cnt = 0;
   int  pass_cnt  = 0;

   imem_loader #(.ADDR_W(32), .CNT_W(16), .TIMEOUT(16)) dut (
      .SYS_clk    (SYS_clk),
      .SYS_reset  (SYS_reset),
      .load_start (load_start),
      .load_base  (load_base),
      .load_words (load_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .load_err   (load_err),
      .checksum   (checksum)
   );

   initial SYS_clk = 1'b0;
   always #5 SYS_clk = ~SYS_clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp)
         pass_cnt++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Write monitor: every IMEM strobe must match the oldest queued expectation.
   always @(negedge SYS_clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("[TB] FAIL unexpected write: got addr 0x%0h data 0x%0h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_output("write addr", 64'(imem_addr), 64'(e.addr));
            check_output("write data", 64'(imem_wdata), 64'(e.data));
         end
      end
   end

   task automatic tick();
      @(posedge SYS_clk);
      #1;
   endtask

   task automatic start_load(input logic [31:0] base, input logic [15:0] words);
      load_start = 1'b1;
      load_base  = base;
      load_words = words;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int budget;
      budget     = 40;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0)
         check_output("byte accept timeout", 64'(byte_ready), 64'(1));
      else
         tick();
      byte_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (load_done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_output({name, " done pulse"}, 64'(load_done), 64'(1));
      check_output({name, " hold in done"}, 64'(cpu_hold), 64'(1));
      tick();
      check_output({name, " done cleared"}, 64'(load_done), 64'(0));
      check_output({name, " hold released"}, 64'(cpu_hold), 64'(0));
      check_output({name, " busy released"}, 64'(load_busy), 64'(0));
   endtask

   initial begin
      logic [7:0] bytes1[8];
      bytes1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};

      SYS_reset  = 1'b1;
      load_start = 1'b0;
      load_base  = '0;
      load_words = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (3) tick();
      SYS_reset = 1'b0;
      tick();

      check_output("reset hold", 64'(cpu_hold), 64'(0));
      check_output("reset busy", 64'(load_busy), 64'(0));
      check_output("reset ready", 64'(byte_ready), 64'(0));
      check_output("reset err", 64'(load_err), 64'(0));
      check_output("reset checksum", 64'(checksum), 64'(0));

      // Two-word load, back-to-back bytes
      exp_q.push_back('{32'h40, 32'h20080005});
      exp_q.push_back('{32'h44, 32'hAC010000});
      start_load(32'h40, 16'd2);
      check_output("load1 hold", 64'(cpu_hold), 64'(1));
      check_output("load1 busy", 64'(load_busy), 64'(1));
      foreach (bytes1[i]) send_byte(bytes1[i]);
      wait_done("load1");
      check_output("load1 checksum", 64'(checksum), 64'(8'hDA));

      // Zero-word load
      start_load(32'h80, 16'd0);
      check_output("zero done", 64'(load_done), 64'(1));
      check_output("zero hold", 64'(cpu_hold), 64'(0));
      tick();
      check_output("zero done cleared", 64'(load_done), 64'(0));
      check_output("zero hold after", 64'(cpu_hold), 64'(0));

      // Timeout after two bytes, then recovery
      start_load(32'h100, 16'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (15) tick();
      check_output("timeout not yet", 64'(load_err), 64'(0));
      tick();
      check_output("timeout err", 64'(load_err), 64'(1));
      check_output("timeout hold", 64'(cpu_hold), 64'(1));
      check_output("timeout ready", 64'(byte_ready), 64'(0));
      repeat (3) tick();
      check_output("err sticky", 64'(load_err), 64'(1));
      exp_q.push_back('{32'h200, 32'hDEADBEEF});
      start_load(32'h200, 16'd1);
      check_output("err cleared", 64'(load_err), 64'(0));
      check_output("checksum cleared", 64'(checksum), 64'(0));
      send_byte(8'hDE);
      send_byte(8'hAD);
      send_byte(8'hBE);
      send_byte(8'hEF);
      wait_done("recover");
      check_output("recover checksum", 64'(checksum), 64'(8'h38));

      // Reset after three accepted bytes
      start_load(32'h300, 16'd1);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      SYS_reset = 1'b1;
      tick();
      check_output("midreset hold", 64'(cpu_hold), 64'(0));
      check_output("midreset busy", 64'(load_busy), 64'(0));
      check_output("midreset we", 64'(imem_we), 64'(0));
      check_output("midreset checksum", 64'(checksum), 64'(0));
      check_output("midreset wdata", 64'(imem_wdata), 64'(0));
      SYS_reset = 1'b0;
      tick();
      exp_q.push_back('{32'h300, 32'h0A0B0C0D});
      start_load(32'h300, 16'd1);
      send_byte(8'h0A);
      send_byte(8'h0B);
      send_byte(8'h0C);
      send_byte(8'h0D);
      wait_done("postreset");

      // Address wrap at the top of memory
      exp_q.push_back('{32'hFFFFFFFC, 32'h01020304});
      exp_q.push_back('{32'h00000000, 32'h05060708});
      start_load(32'hFFFFFFFC, 16'd2);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      wait_done("wrap");
      check_output("wrap checksum", 64'(checksum), 64'(8'h24));

      // Stray bytes in IDLE, unaligned base, ignored second start
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      tick();
      check_output("idle ready", 64'(byte_ready), 64'(0));
      tick();
      check_output("idle checksum", 64'(checksum), 64'(8'h24));
      byte_valid = 1'b0;
      exp_q.push_back('{32'h40, 32'hCAFEF00D});
      start_load(32'h43, 16'd1);
      send_byte(8'hCA);
      start_load(32'h80, 16'd5);
      send_byte(8'hFE);
      send_byte(8'hF0);
      send_byte(8'h0D);
      wait_done("unaligned");

      repeat (5) tick();
      check_output("writes outstanding", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
